// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERR
   } loader_state_e;

   localparam logic [7:0] CSUM_INIT = 8'h00;
   localparam int         HDR_LEN   = 2;

   // True in the states that consume stream bytes.
   function automatic logic is_session(input loader_state_e s);
      return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/word_packer.sv
// Packs four accepted bytes little-endian into one 32-bit word.
module word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  data,
   input  logic        accept,
   input  logic        clear,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  lane_reg;
   logic [23:0] shift_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_reg  <= 2'd0;
         shift_reg <= 24'd0;
      end else if (clear) begin
         lane_reg  <= 2'd0;
         shift_reg <= 24'd0;
      end else if (accept) begin
         lane_reg  <= lane_reg + 2'd1;
         shift_reg <= {data, shift_reg[23:8]};
      end
   end

   // Lane 3 completes the word straight from the input byte.
   assign word       = {data, shift_reg};
   assign word_valid = accept && (lane_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction RAM; holds the core in reset until a clean load.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        we,
   output logic [31:0] waddr,
   output logic [31:0] wdata,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   loader_state_e state_reg, state_next;

   logic [15:0]   count_reg;
   logic [AW-1:0] index_reg;
   logic [7:0]    csum_reg;

   logic          rx_ready_reg, rx_ready_next;
   logic          we_reg, we_next;
   logic [31:0]   waddr_reg, waddr_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic          core_hold_reg, core_hold_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          err_reg, err_next;

   logic          accept;
   logic          session_start;
   logic [15:0]   count_full;
   logic          last_word;
   logic          pk_accept;
   logic [31:0]   pk_word;
   logic          pk_valid;

   assign accept        = rx_valid && rx_ready_reg;
   assign session_start = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE) ||
                                    (state_reg == ST_ERR));
   assign count_full    = {rx_data, count_reg[7:0]};
   assign last_word     = (16'(index_reg) + 16'd1) == count_reg;
   assign pk_accept     = accept && (state_reg == ST_DATA);

   word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .data       (rx_data),
      .accept     (pk_accept),
      .clear      (session_start),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_DONE, ST_ERR: if (start) state_next = ST_LEN0;
         ST_LEN0: if (accept) state_next = ST_LEN1;
         ST_LEN1: begin
            if (accept) begin
               if (count_full > 16'(DEPTH))  state_next = ST_ERR;
               else if (count_full == 16'd0) state_next = ST_CSUM;
               else                          state_next = ST_DATA;
            end
         end
         ST_DATA: if (pk_valid && last_word) state_next = ST_CSUM;
         ST_CSUM: begin
            if (accept) state_next = (rx_data == csum_reg) ? ST_DONE : ST_ERR;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Status outputs are registered images of the state being entered.
   always_comb begin
      rx_ready_next  = is_session(state_next);
      busy_next      = is_session(state_next);
      done_next      = (state_next == ST_DONE);
      err_next       = (state_next == ST_ERR);
      core_hold_next = (state_next != ST_DONE);
      we_next        = pk_valid;
      waddr_next     = waddr_reg;
      wdata_next     = wdata_reg;
      if (pk_valid) begin
         waddr_next = 32'({index_reg, 2'b00});
         wdata_next = pk_word;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg     <= 16'd0;
         index_reg     <= '0;
         csum_reg      <= CSUM_INIT;
         rx_ready_reg  <= 1'b0;
         we_reg        <= 1'b0;
         waddr_reg     <= 32'd0;
         wdata_reg     <= 32'd0;
         core_hold_reg <= 1'b1;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         if (session_start) begin
            count_reg <= 16'd0;
            index_reg <= '0;
            csum_reg  <= CSUM_INIT;
         end else if (accept) begin
            case (state_reg)
               ST_LEN0: count_reg[7:0]  <= rx_data;
               ST_LEN1: count_reg[15:8] <= rx_data;
               ST_DATA: begin
                  csum_reg <= csum_reg ^ rx_data;
                  // Hold at the final index so it never wraps.
                  if (pk_valid && !last_word) index_reg <= index_reg + 1'b1;
               end
               default: ;
            endcase
         end
         rx_ready_reg  <= rx_ready_next;
         we_reg        <= we_next;
         waddr_reg     <= waddr_next;
         wdata_reg     <= wdata_next;
         core_hold_reg <= core_hold_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   assign rx_ready  = rx_ready_reg;
   assign we        = we_reg;
   assign waddr     = waddr_reg;
   assign wdata     = wdata_reg;
   assign core_hold = core_hold_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued, a monitor checks each we pulse.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        we;
   logic [31:0] waddr;
   logic [31:0] wdata;
   logic        core_hold;
   logic        busy;
   logic        done;
   logic        err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];

   imem_loader #(.DEPTH(64)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .core_hold (core_hold),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (we === 1'b1) begin
         $display("write addr=0x%08h data=0x%08h", waddr, wdata);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", waddr, wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (waddr !== e.addr || wdata !== e.data) begin
               errors++;
               $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                        waddr, wdata, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic send_byte(input logic [7:0] b, input bit stall);
      int n;
      if (stall) begin
         n = 0;
         while ($urandom_range(0, 1) == 1 && n < 4) begin
            rx_valid = 1'b0;
            @(negedge clk);
            n++;
         end
      end
      rx_data  = b;
      rx_valid = 1'b1;
      n = 0;
      while (rx_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (rx_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout: byte 0x%02h not accepted within 20 cycles", b);
      end
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_stream(input logic [7:0] s[$], input bit stall);
      foreach (s[i]) send_byte(s[i], stall);
      rx_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e,
                               input logic h, input logic b);
      check({tag, "_done"}, 32'(done), 32'(d));
      check({tag, "_err"}, 32'(err), 32'(e));
      check({tag, "_core_hold"}, 32'(core_hold), 32'(h));
      check({tag, "_busy"}, 32'(busy), 32'(b));
      check({tag, "_rx_ready"}, 32'(rx_ready), 32'(b));
   endtask

   logic [7:0] good[$];
   logic [7:0] bad[$];

   initial begin
      good = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40, 8'hC0};
      bad  = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40, 8'hC1};

      // Reset values
      repeat (2) @(negedge clk);
      check_status("reset", 1'b0, 1'b0, 1'b1, 1'b0);
      check("reset_we", 32'(we), 32'd0);
      check("reset_waddr", waddr, 32'd0);
      check("reset_wdata", wdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Two-word load
      pulse_start();
      check_status("start", 1'b0, 1'b0, 1'b1, 1'b1);
      push_wr(32'd0, 32'h0011_0233);
      push_wr(32'd4, 32'h4011_02B3);
      send_stream(good, 1'b0);
      check_status("good", 1'b1, 1'b0, 1'b0, 1'b0);
      drain("good_pending");

      // Bad checksum: writes still happen
      pulse_start();
      push_wr(32'd0, 32'h0011_0233);
      push_wr(32'd4, 32'h4011_02B3);
      send_stream(bad, 1'b0);
      check_status("badcsum", 1'b0, 1'b1, 1'b1, 1'b0);
      drain("badcsum_pending");

      // Oversize count 0x0041
      pulse_start();
      send_byte(8'h41, 1'b0);
      send_byte(8'h00, 1'b0);
      check_status("oversize", 1'b0, 1'b1, 1'b1, 1'b0);
      rx_data = 8'hAA;
      repeat (4) @(negedge clk);
      check("oversize_rx_ready_hold", 32'(rx_ready), 32'd0);
      rx_valid = 1'b0;
      drain("oversize_pending");

      // Zero-word loads
      pulse_start();
      send_stream('{8'h00, 8'h00, 8'h00}, 1'b0);
      check_status("zero_good", 1'b1, 1'b0, 1'b0, 1'b0);
      pulse_start();
      send_stream('{8'h00, 8'h00, 8'h01}, 1'b0);
      check_status("zero_bad", 1'b0, 1'b1, 1'b1, 1'b0);
      drain("zero_pending");

      // Stalled load with a start pulse mid-DATA that must be ignored
      pulse_start();
      push_wr(32'd0, 32'h0011_0233);
      push_wr(32'd4, 32'h4011_02B3);
      foreach (good[i]) begin
         if (i == 6) begin
            rx_valid = 1'b0;
            pulse_start();
            check_status("ignored_start", 1'b0, 1'b0, 1'b1, 1'b1);
         end
         send_byte(good[i], 1'b1);
      end
      rx_valid = 1'b0;
      check_status("stall", 1'b1, 1'b0, 1'b0, 1'b0);
      drain("stall_pending");

      // Restart after DONE begins again at address 0
      pulse_start();
      check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
      push_wr(32'd0, 32'h0011_0233);
      push_wr(32'd4, 32'h4011_02B3);
      send_stream(good, 1'b0);
      check_status("restart_done", 1'b1, 1'b0, 1'b0, 1'b0);
      drain("restart_pending");

      // Reset just after the 6th byte: in-flight write is dropped
      pulse_start();
      for (int i = 0; i < 5; i++) send_byte(good[i], 1'b0);
      rx_data  = good[5];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_status("midreset", 1'b0, 1'b0, 1'b1, 1'b0);
      check("midreset_we", 32'(we), 32'd0);
      check("midreset_waddr", waddr, 32'd0);
      check("midreset_wdata", wdata, 32'd0);
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      pulse_start();
      push_wr(32'd0, 32'h0011_0233);
      push_wr(32'd4, 32'h4011_02B3);
      send_stream(good, 1'b0);
      check_status("after_reset", 1'b1, 1'b0, 1'b0, 1'b0);
      drain("after_reset_pending");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
